// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit op decoder.
//
// Holds the op-select encodings reported on op_found, the decoder state
// encodings, the default sample budget per decode run, and a small popcount
// helper used when classifying the candidate mask.
package lu_pkg;

  // Select values of the unknown logic unit, in candidate-mask bit order
  typedef enum logic [1:0] {
    OP_OR   = 2'b00,
    OP_NOR  = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_OBSERVE = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

  localparam int MAX_SAMPLES_DEFAULT = 4;

  localparam logic [3:0] CAND_ALL = 4'b1111;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/lu_ref_eval.sv
// Reference evaluator for the four candidate operations.
//
// Applies every candidate op to the operand pair and reports which ones
// agree with the observed result bit.
//   a, b  : operand bits applied to the unknown logic unit
//   s     : observed result bit
//   cons  : bit i set when op i (lu_pkg::op_sel_e order) applied to (a, b)
//           yields s
module lu_ref_eval
  import lu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       s,
  output logic [3:0] cons
);

  always_comb begin
    cons           = 4'b0000;
    cons[OP_OR]    = ((a | b) == s);
    cons[OP_NOR]   = (~(a | b) == s);
    cons[OP_XOR]   = ((a ^ b) == s);
    cons[OP_XNOR]  = (~(a ^ b) == s);
  end

endmodule

// File: rtl/lu_op_decoder.sv
// Decodes which op (OR, NOR, XOR, XNOR) an unknown logic unit performs by
// eliminating candidates against observed (a, b, s) samples.
//
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   start             : begin (or restart) a decode run
//   in_valid, a, b, s : observed sample from the unknown unit
//   in_ready          : a sample is accepted this cycle (OBSERVE only)
//   done              : run finished, status outputs valid
//   op_found          : decoded select when found=1, else 00
//   found/ambiguous/error : one / two or more / zero candidates remain
//   cand              : candidate mask, bit i = op i still consistent
//   sample_count      : samples accepted in the current run
module lu_op_decoder
  import lu_pkg::*;
#(
  parameter int MAX_SAMPLES = MAX_SAMPLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       s,
  output logic       in_ready,
  output logic       done,
  output logic [1:0] op_found,
  output logic       found,
  output logic       ambiguous,
  output logic       error,
  output logic [3:0] cand,
  output logic [2:0] sample_count
);

  state_e     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [2:0] count_q, count_d;
  logic [3:0] cons;
  logic [2:0] cand_pop;

  lu_ref_eval u_ref_eval (
    .a    (a),
    .b    (b),
    .s    (s),
    .cons (cons)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cand_q  <= CAND_ALL;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      count_q <= count_d;
    end
  end

  // start always wins over a sample offered in the same cycle, so a restart
  // never folds a stale observation into the fresh candidate mask.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_OBSERVE;
          cand_d  = CAND_ALL;
          count_d = 3'd0;
        end
      end
      ST_OBSERVE: begin
        if (start) begin
          cand_d  = CAND_ALL;
          count_d = 3'd0;
        end else if (in_valid) begin
          cand_d  = cand_q & cons;
          count_d = count_q + 3'd1;
          if ((popcount4(cand_d) <= 3'd1) || (count_d == 3'(MAX_SAMPLES))) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cand_d  = CAND_ALL;
        count_d = 3'd0;
      end
    endcase
  end

  // Status is decoded purely from registered state and mask.
  always_comb begin
    cand_pop  = popcount4(cand_q);
    in_ready  = (state_q == ST_OBSERVE);
    done      = (state_q == ST_DONE);
    found     = done && (cand_pop == 3'd1);
    ambiguous = done && (cand_pop >= 3'd2);
    error     = done && (cand_pop == 3'd0);
    op_found  = OP_OR;
    if (found) begin
      unique case (cand_q)
        4'b0010: op_found = OP_NOR;
        4'b0100: op_found = OP_XOR;
        4'b1000: op_found = OP_XNOR;
        default: op_found = OP_OR;
      endcase
    end
  end

  assign cand         = cand_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_lu_op_decoder.sv
// Directed testbench for lu_op_decoder with hand-computed expectations.
module tb_lu_op_decoder;

  logic       clk;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic       a, b, s;
  logic       in_ready;
  logic       done;
  logic [1:0] op_found;
  logic       found, ambiguous, error;
  logic [3:0] cand;
  logic [2:0] sample_count;

  int checkCount;
  int passCount;

  lu_op_decoder #(.MAX_SAMPLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .a            (a),
    .b            (b),
    .s            (s),
    .in_ready     (in_ready),
    .done         (done),
    .op_found     (op_found),
    .found        (found),
    .ambiguous    (ambiguous),
    .error        (error),
    .cand         (cand),
    .sample_count (sample_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its expected value and tallies it
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Status bundle {in_ready, done, found, ambiguous, error}
  task automatic checkStatus(input string tag, input logic [4:0] exp);
    checkOutput(tag, {3'b000, in_ready, done, found, ambiguous, error}, {3'b000, exp});
  endtask

  // Drives start and/or one sample for exactly one rising edge
  task automatic applyStimulus(input logic st, input logic v, input logic ia, input logic ib, input logic is);
    @(negedge clk);
    start    = st;
    in_valid = v;
    a        = ia;
    b        = ib;
    s        = is;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    a          = 1'b0;
    b          = 1'b0;
    s          = 1'b0;

    #12;
    checkStatus("reset_status", 5'b00000);
    checkOutput("reset_cand", 8'(cand), 8'h0F);
    checkOutput("reset_count", 8'(sample_count), 8'd0);
    checkOutput("reset_op", 8'(op_found), 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Sample in IDLE is ignored
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkStatus("idle_valid_status", 5'b00000);
    checkOutput("idle_valid_cand", 8'(cand), 8'h0F);
    checkOutput("idle_valid_count", 8'(sample_count), 8'd0);

    // XOR decode
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkStatus("xor_start_status", 5'b10000);
    checkOutput("xor_start_cand", 8'(cand), 8'h0F);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("xor_s1_cand", 8'(cand), 8'h06);
    checkOutput("xor_s1_count", 8'(sample_count), 8'd1);
    checkStatus("xor_s1_status", 5'b10000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("xor_s2_cand", 8'(cand), 8'h04);
    checkStatus("xor_done_status", 5'b01100);
    checkOutput("xor_op", 8'(op_found), 8'd2);
    checkOutput("xor_count", 8'(sample_count), 8'd2);

    // DONE holds with no input activity
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkStatus("done_hold_status", 5'b01100);
    checkOutput("done_hold_cand", 8'(cand), 8'h04);

    // XNOR decode, restarting from DONE
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("xnor_start_count", 8'(sample_count), 8'd0);
    checkOutput("xnor_start_cand", 8'(cand), 8'h0F);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("xnor_s1_cand", 8'(cand), 8'h0A);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("xnor_s2_cand", 8'(cand), 8'h08);
    checkStatus("xnor_done_status", 5'b01100);
    checkOutput("xnor_op", 8'(op_found), 8'd3);
    checkOutput("xnor_count", 8'(sample_count), 8'd2);

    // Ambiguous: four identical samples exhaust the budget
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    checkOutput("amb_s3_count", 8'(sample_count), 8'd3);
    checkStatus("amb_s3_status", 5'b10000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("amb_cand", 8'(cand), 8'h05);
    checkStatus("amb_status", 5'b01010);
    checkOutput("amb_op", 8'(op_found), 8'd0);
    checkOutput("amb_count", 8'(sample_count), 8'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("amb_nocount_past_max", 8'(sample_count), 8'd4);

    // Error: no candidate survives
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkStatus("err_s1_status", 5'b10000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("err_cand", 8'(cand), 8'h00);
    checkStatus("err_status", 5'b01001);
    checkOutput("err_op", 8'(op_found), 8'd0);

    // Asynchronous reset mid-run
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("areset_pre_cand", 8'(cand), 8'h06);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkStatus("areset_status", 5'b00000);
    checkOutput("areset_cand", 8'(cand), 8'h0F);
    checkOutput("areset_count", 8'(sample_count), 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Restart in OBSERVE discards the simultaneous sample
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("restart_pre_cand", 8'(cand), 8'h06);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("restart_cand", 8'(cand), 8'h0F);
    checkOutput("restart_count", 8'(sample_count), 8'd0);
    checkStatus("restart_status", 5'b10000);

    // in_valid alone in DONE changes nothing
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkStatus("done_pre_status", 5'b01100);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("done_valid_cand", 8'(cand), 8'h04);
    checkOutput("done_valid_count", 8'(sample_count), 8'd2);
    checkStatus("done_valid_status", 5'b01100);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
